stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 147 ++++++++++++++
 tb/tb_stack_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Full-descending stack controller: drives an external SP block and a word memory.
// Optional `STACK_BOUND_CHECK_EN: flags overflow/underflow in StackErr instead of saturating.
module stack_ctrl #(
    parameter logic [31:0] STACK_TOP = 32'h0000_0100,
    parameter int          DEPTH     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PushReq,
    input  logic        PopReq,
    input  logic [31:0] PushData,
    output logic [31:0] PopData,
    output logic        Ack,
    output logic        Busy,
    output logic        StackErr,
    output logic [1:0]  SPDrive,
    output logic [31:0] SPSet,
    input  logic [31:0] SPOutput,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic        MemWE,
    output logic        MemRE,
    input  logic [31:0] MemRData,
    input  logic        MemReady
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;
    localparam logic [1:0] SP_LOAD = 2'b11;

    typedef enum logic [2:0] {
        INIT, IDLE, PUSH_DEC, PUSH_WR, POP_RD, POP_INC, ACK
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;

    assign Busy = (state != IDLE);
    // The address follows the live SP only while a strobe is up, so it tracks the decrement
    // made in PUSH_DEC without a one-cycle lag.
    assign MemAddr = (MemWE || MemRE) ? SPOutput : '0;

`ifdef STACK_BOUND_CHECK_EN
    logic stack_err;
    assign StackErr = stack_err;
`else
    assign StackErr = 1'b0;
`endif

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            count    <= '0;
            PopData  <= '0;
            MemWData <= '0;
            Ack      <= 1'b0;
            SPDrive  <= SP_HOLD;
            SPSet    <= '0;
            MemWE    <= 1'b0;
            MemRE    <= 1'b0;
`ifdef STACK_BOUND_CHECK_EN
            stack_err <= 1'b0;
`endif
        end else begin
            case (state)
                // First INIT cycle raises the load command, second one retires it.
                INIT: begin
                    count <= '0;
                    if (SPDrive == SP_LOAD) begin
                        SPDrive <= SP_HOLD;
                        state   <= IDLE;
                    end else begin
                        SPDrive <= SP_LOAD;
                        SPSet   <= STACK_TOP;
                    end
                end
                IDLE: begin
                    if (PushReq) begin
`ifdef STACK_BOUND_CHECK_EN
                        if (count == FULL) begin
                            stack_err <= 1'b1;
                            Ack       <= 1'b1;
                            state     <= ACK;
                        end else
`endif
                        begin
                            SPDrive  <= SP_DEC;
                            MemWData <= PushData;
                            state    <= PUSH_DEC;
                        end
                    end else if (PopReq) begin
`ifdef STACK_BOUND_CHECK_EN
                        if (count == '0) begin
                            stack_err <= 1'b1;
                            Ack       <= 1'b1;
                            state     <= ACK;
                        end else
`endif
                        begin
                            MemRE <= 1'b1;
                            state <= POP_RD;
                        end
                    end
                end
                PUSH_DEC: begin
                    SPDrive <= SP_HOLD;
                    MemWE   <= 1'b1;
                    state   <= PUSH_WR;
                end
                PUSH_WR: begin
                    if (MemReady) begin
                        MemWE <= 1'b0;
                        if (count != FULL) count <= count + 1'b1;
                        Ack   <= 1'b1;
                        state <= ACK;
                    end
                end
                POP_RD: begin
                    if (MemReady) begin
                        MemRE   <= 1'b0;
                        PopData <= MemRData;
                        SPDrive <= SP_INC;
                        state   <= POP_INC;
                    end
                end
                POP_INC: begin
                    SPDrive <= SP_HOLD;
                    if (count != '0) count <= count - 1'b1;
                    Ack     <= 1'b1;
                    state   <= ACK;
                end
                ACK: begin
                    Ack   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl (DEPTH=4): SP block and word memory models, vector table plus
// hand-written latency, stall and reset sequences. Adapts to `STACK_BOUND_CHECK_EN.
module tb_stack_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        PushReq, PopReq;
    logic [31:0] PushData;
    logic [31:0] PopData;
    logic        Ack, Busy, StackErr;
    logic [1:0]  SPDrive;
    logic [31:0] SPSet, SPOutput, MemAddr, MemWData, MemRData;
    logic        MemWE, MemRE, MemReady;

    logic [31:0] sp;
    logic [31:0] mem [256];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        push;
        logic        pop;
        logic [31:0] data;
        logic [31:0] exp_pop;
        logic [31:0] exp_sp;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];

    stack_ctrl #(.STACK_TOP(32'h0000_0100), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .PushReq(PushReq), .PopReq(PopReq), .PushData(PushData),
        .PopData(PopData), .Ack(Ack), .Busy(Busy), .StackErr(StackErr),
        .SPDrive(SPDrive), .SPSet(SPSet), .SPOutput(SPOutput),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemWE(MemWE), .MemRE(MemRE),
        .MemRData(MemRData), .MemReady(MemReady)
    );

    always #5 clk = ~clk;

    // External stack pointer block.
    always @(posedge clk) begin
        case (SPDrive)
            2'b01:   sp <= sp + 32'd1;
            2'b10:   sp <= sp - 32'd1;
            2'b11:   sp <= SPSet;
            default: sp <= sp;
        endcase
    end
    assign SPOutput = sp;

    always @(posedge clk) if (MemWE && MemReady) mem[MemAddr[7:0]] <= MemWData;
    assign MemRData = mem[MemAddr[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!Ack && cyc < 40);
        check("ack_seen", {31'd0, Ack}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        @(negedge clk);
        PushReq  = v.push;
        PopReq   = v.pop;
        PushData = v.data;
        if (v.pop) sb_q.push_back(v.exp_pop);
        wait_ack(cyc);
        if (v.push && v.pop) begin
            check("both_push_sp", sp, v.exp_sp - 32'd1);
            PushReq = 1'b0;
            wait_ack(cyc);
        end
        PushReq = 1'b0;
        PopReq  = 1'b0;
        if (v.pop && sb_q.size() > 0) check("pop_data", PopData, sb_q.pop_front());
        check("sp", sp, v.exp_sp);
        check("stack_err", {31'd0, StackErr}, {31'd0, v.exp_err});
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, re_cnt, load_cnt;
        logic [31:0] load_val;

        rst = 1'b1; PushReq = 1'b0; PopReq = 1'b0; PushData = '0; MemReady = 1'b1;

        // Table: inputs and expected PopData / SP / StackErr after each Ack.
        vecs.push_back('{1'b0, 1'b1, 32'h0,  32'hA5A5_0001, 32'h100, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h11, 32'h0,  32'hFF,  1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h22, 32'h0,  32'hFE,  1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0,  32'h22, 32'hFF,  1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0,  32'h11, 32'h100, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h33, 32'h33, 32'h100, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h1,  32'h0,  32'hFF,  1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h2,  32'h0,  32'hFE,  1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h3,  32'h0,  32'hFD,  1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h4,  32'h0,  32'hFC,  1'b0});
`ifdef STACK_BOUND_CHECK_EN
        vecs.push_back('{1'b1, 1'b0, 32'h5,  32'h0,  32'hFC,  1'b1});
`else
        vecs.push_back('{1'b1, 1'b0, 32'h5,  32'h0,  32'hFB,  1'b0});
`endif

        // Reset values, then a single SP load cycle.
        repeat (3) @(negedge clk);
        check("rst_spdrive", {30'd0, SPDrive}, 32'd0);
        check("rst_spset", SPSet, 32'd0);
        check("rst_ack", {31'd0, Ack}, 32'd0);
        check("rst_strobes", {30'd0, MemWE, MemRE}, 32'd0);
        check("rst_memaddr", MemAddr, 32'd0);
        check("rst_popdata", PopData, 32'd0);
        check("rst_memwdata", MemWData, 32'd0);
        rst = 1'b0;
        load_cnt = 0;
        load_val = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (SPDrive == 2'b11) begin
                load_cnt++;
                load_val = SPSet;
            end
        end
        check("init_load_cycles", load_cnt, 32'd1);
        check("init_spset", load_val, 32'h100);
        check("init_sp", sp, 32'h100);
        check("idle_busy", {31'd0, Busy}, 32'd0);

        // Push latency: SP decrement, write at 0xFF, Ack on the third cycle.
        @(negedge clk);
        PushReq = 1'b1; PushData = 32'hA5A5_0001;
        @(negedge clk);
        check("push_c1_spdrive", {30'd0, SPDrive}, 32'd2);
        check("push_c1_busy", {31'd0, Busy}, 32'd1);
        @(negedge clk);
        check("push_c2_spdrive", {30'd0, SPDrive}, 32'd0);
        check("push_c2_memwe", {31'd0, MemWE}, 32'd1);
        check("push_c2_memaddr", MemAddr, 32'hFF);
        check("push_c2_wdata", MemWData, 32'hA5A5_0001);
        check("push_c2_ack", {31'd0, Ack}, 32'd0);
        @(negedge clk);
        check("push_c3_ack", {31'd0, Ack}, 32'd1);
        check("push_c3_memwe", {31'd0, MemWE}, 32'd0);
        PushReq = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        apply_reset();
        check("rerst_sp", sp, 32'h100);
        check("rerst_err", {31'd0, StackErr}, 32'd0);

`ifdef STACK_BOUND_CHECK_EN
        run_vec('{1'b0, 1'b1, 32'h0, 32'h0, 32'h100, 1'b1});
        apply_reset();
`endif

        // Pop with MemReady low for three sampled cycles.
        run_vec('{1'b1, 1'b0, 32'h44, 32'h0, 32'hFF, 1'b0});
        @(negedge clk);
        MemReady = 1'b0;
        PopReq   = 1'b1;
        cyc = 0;
        re_cnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (MemRE) re_cnt++;
            if (cyc == 4) MemReady = 1'b1;
        end while (!Ack && cyc < 40);
        PopReq = 1'b0;
        check("stall_ack_cycle", cyc, 32'd6);
        check("stall_memre_cycles", re_cnt, 32'd4);
        check("stall_popdata", PopData, 32'h44);
        check("stall_sp", sp, 32'h100);

        // Reset during POP_RD drops the read strobe without waiting for a clock.
        run_vec('{1'b1, 1'b0, 32'h55, 32'h0, 32'hFF, 1'b0});
        @(negedge clk);
        MemReady = 1'b0;
        PopReq   = 1'b1;
        @(negedge clk);
        check("rd_memre", {31'd0, MemRE}, 32'd1);
        check("rd_memaddr", MemAddr, 32'hFF);
        #2 rst = 1'b1;
        #1;
        check("async_memre", {31'd0, MemRE}, 32'd0);
        check("async_memaddr", MemAddr, 32'd0);
        PopReq   = 1'b0;
        MemReady = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reload_sp", sp, 32'h100);
        check("reload_busy", {31'd0, Busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
